arbiter_rr_desc: RTL and testbench
==================================

ARBITER_RR_DESC -- requirements
Module: arbiter_rr_desc

Interface
REQ-001 Parameter MAIN_MEM_ADDR_WIDTH, default 32: main memory address width.
REQ-002 Parameter NUM_CORES, default 4: PE array cores arbitrated (>=2).
REQ-003 Parameter BURST_WIDTH, default 6: burst length width.
REQ-004 Parameter NUM_READ_STAGES, default 3: read descriptors per load grant (config, weights, acts).
REQ-005 w_clock  in  1  clock; all state on rising edge.
REQ-006 w_reset_n  in  1  reset; asynchronous, active-low.
REQ-007 w_req  in  NUM_CORES  per-core request, level.
REQ-008 w_grant  out  NUM_CORES  one-hot grant, registered.
REQ-009 w_desc_valid  in  1  descriptor available.
REQ-010 w_desc_ready  out  1  arbiter accepts descriptor.
REQ-011 w_desc_addr  in  MAIN_MEM_ADDR_WIDTH  descriptor start address.
REQ-012 w_desc_burst  in  BURST_WIDTH  descriptor beat count.
REQ-013 w_mem_ready  in  1  memory accepts current header/beat.
REQ-014 w_burst  out  BURST_WIDTH  burst length, meaningful when w_burst_valid.
REQ-015 w_burst_valid  out  1  header cycle.
REQ-016 w_addr  out  MAIN_MEM_ADDR_WIDTH  beat address, meaningful when w_addr_valid.
REQ-017 w_addr_valid  out  1  address beat cycle.
REQ-018 w_rw  out  1  1 = read (load to core), 0 = write (psum unload).
REQ-019 w_busy  out  1  high in every state except IDLE.

Function
REQ-020 States SHALL be IDLE, ARB, DESC, HDR, XFER, DONE; no others reachable.
REQ-021 IDLE -> ARB when w_req != 0; ARB lasts exactly one cycle -> DESC.
REQ-022 ARB SHALL select the first set w_req bit searching upward from (last_sel+1) mod NUM_CORES, wrapping; last_sel resets to NUM_CORES-1 so core 0 wins first.
REQ-023 w_grant SHALL assert one-hot for the selected core from the first DESC cycle until the DONE cycle, then clear.
REQ-024 Per-core mode bit r_load (reset 0): 0 -> grant is read of NUM_READ_STAGES descriptors, w_rw=1; 1 -> grant is write of one descriptor, w_rw=0; bit toggles in DONE.
REQ-025 DESC: w_desc_ready=1; on w_desc_valid&&w_desc_ready latch addr/burst, go HDR; otherwise hold.
REQ-026 HDR: w_burst_valid=1, w_burst=latched burst; advance on w_mem_ready; burst 0 goes directly to stage-end logic (no beats).
REQ-027 XFER: w_addr_valid=1, w_addr = start + beat index, modulo 2^MAIN_MEM_ADDR_WIDTH; beat advances only on w_mem_ready; exactly burst beats issued.
REQ-028 w_mem_ready low in HDR/XFER SHALL hold w_burst, w_addr, w_rw, beat index unchanged.
REQ-029 Stage end: if more stages remain for this grant -> DESC, else -> DONE.
REQ-030 DONE: one cycle; update last_sel, toggle r_load[sel], clear grant -> IDLE.
REQ-031 w_req changes after ARB SHALL NOT abort or alter the current grant.
REQ-032 w_desc_ready, w_burst_valid, w_addr_valid SHALL be mutually exclusive and 0 outside DESC/HDR/XFER.
REQ-033 w_burst and w_addr SHALL read 0 when their valid is low.

Reset
REQ-034 w_reset_n low SHALL immediately force IDLE, w_grant=0, all valids 0, w_desc_ready=0, w_busy=0, w_burst=0, w_addr=0, w_rw=0, all r_load=0, last_sel=NUM_CORES-1, counters 0, including mid-transfer.
REQ-035 First rising edge with w_reset_n high SHALL be evaluated from IDLE.

Verification
REQ-036 Single read: w_req=4'b0010, descriptors (0x100,4),(0x200,2),(0x300,1), w_mem_ready=1 -> grant 0010, headers 4/2/1, addresses 0x100-0x103, 0x200-0x201, 0x300, w_rw=1, grant clears after.
REQ-037 Alternation: repeat core 1 request with descriptor (0x400,3) -> one header 3, addresses 0x400-0x402, w_rw=0; third request reads again.
REQ-038 Round-robin: w_req=4'b1111 held -> grant order 0001,0010,0100,1000,0001.
REQ-039 Backpressure/wrap: descriptor (0xFFFFFFFE,4), w_mem_ready low every other cycle -> addresses FFFFFFFE, FFFFFFFF, 0, 1, each held while stalled.
REQ-040 Edge cases: burst 0 descriptor -> header only, no beats; w_desc_valid delayed 5 cycles -> stays in DESC, ready high.
REQ-041 Reset mid-XFER (beat 2 of 4) -> all outputs 0 asynchronously; next request granted to core 0 as read.

Source files
------------

// File: rtl/arbiter_rr_desc_if.sv
// ---------------------------------------------------------------------------
// arbiter_rr_desc_if
// Bundles the request/grant, descriptor and memory-header/beat signals of the
// round-robin descriptor arbiter.
//   master : core/descriptor/memory side (drives requests, descriptors,
//            memory ready; observes grant and the transfer stream)
//   slave  : the arbiter itself
// Signals:
//   w_req/w_grant             per-core level request / one-hot grant
//   w_desc_valid/ready/addr/burst  descriptor handshake and payload
//   w_mem_ready               memory accepts the current header or beat
//   w_burst/w_burst_valid     header cycle and its burst length
//   w_addr/w_addr_valid       beat cycle and its address
//   w_rw                      1 = read (load to core), 0 = write (psum unload)
//   w_busy                    arbiter not idle
// ---------------------------------------------------------------------------
interface arbiter_rr_desc_if #(
    parameter int MAIN_MEM_ADDR_WIDTH = 32,
    parameter int NUM_CORES           = 4,
    parameter int BURST_WIDTH         = 6
);
    logic [NUM_CORES-1:0]           w_req;
    logic [NUM_CORES-1:0]           w_grant;
    logic                           w_desc_valid;
    logic                           w_desc_ready;
    logic [MAIN_MEM_ADDR_WIDTH-1:0] w_desc_addr;
    logic [BURST_WIDTH-1:0]         w_desc_burst;
    logic                           w_mem_ready;
    logic [BURST_WIDTH-1:0]         w_burst;
    logic                           w_burst_valid;
    logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr;
    logic                           w_addr_valid;
    logic                           w_rw;
    logic                           w_busy;

    modport master (
        output w_req, w_desc_valid, w_desc_addr, w_desc_burst, w_mem_ready,
        input  w_grant, w_desc_ready, w_burst, w_burst_valid, w_addr,
               w_addr_valid, w_rw, w_busy
    );

    modport slave (
        input  w_req, w_desc_valid, w_desc_addr, w_desc_burst, w_mem_ready,
        output w_grant, w_desc_ready, w_burst, w_burst_valid, w_addr,
               w_addr_valid, w_rw, w_busy
    );
endinterface

// File: rtl/arbiter_rr_desc.sv
// ---------------------------------------------------------------------------
// arbiter_rr_desc
// Round-robin arbiter granting main-memory access to one PE core at a time.
// Each grant alternates per core between a load (NUM_READ_STAGES read
// descriptors: config, weights, activations) and an unload (one write
// descriptor). Every descriptor becomes one header cycle followed by
// 'burst' address beats, all paced by w_mem_ready.
// Ports:
//   w_clock    clock, rising edge
//   w_reset_n  asynchronous active-low reset
//   bus        arbiter_rr_desc_if.slave (request/grant, descriptor, stream)
// All outputs are registered; they are decoded from the next-state values so
// they line up with the state they describe.
// ---------------------------------------------------------------------------
module arbiter_rr_desc #(
    parameter int MAIN_MEM_ADDR_WIDTH = 32,
    parameter int NUM_CORES           = 4,
    parameter int BURST_WIDTH         = 6,
    parameter int NUM_READ_STAGES     = 3
) (
    input  logic               w_clock,
    input  logic               w_reset_n,
    arbiter_rr_desc_if.slave   bus
);

    localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int STG_W = $clog2(NUM_READ_STAGES + 1);
    localparam int PAD_W = MAIN_MEM_ADDR_WIDTH - BURST_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_DESC = 3'd2,
        ST_HDR  = 3'd3,
        ST_XFER = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // FSM and datapath state
    state_t                         state_r, state_next_s;
    logic [NUM_CORES-1:0]           req_snap_r, req_snap_next_s;
    logic [SEL_W-1:0]               sel_r, sel_next_s;
    logic [SEL_W-1:0]               last_sel_r, last_sel_next_s;
    logic [NUM_CORES-1:0]           load_r, load_next_s;
    logic [STG_W-1:0]               stage_r, stage_next_s;
    logic [BURST_WIDTH-1:0]         beat_r, beat_next_s;
    logic [BURST_WIDTH-1:0]         burst_r, burst_next_s;
    logic [MAIN_MEM_ADDR_WIDTH-1:0] base_r, base_next_s;

    // Registered outputs and their next values
    logic [NUM_CORES-1:0]           grant_r, grant_next_s;
    logic                           desc_ready_r, desc_ready_next_s;
    logic                           burst_valid_r, burst_valid_next_s;
    logic [BURST_WIDTH-1:0]         burst_out_r, burst_out_next_s;
    logic                           addr_valid_r, addr_valid_next_s;
    logic [MAIN_MEM_ADDR_WIDTH-1:0] addr_out_r, addr_out_next_s;
    logic                           rw_r, rw_next_s;
    logic                           busy_r, busy_next_s;

    // Arbitration helpers
    logic [SEL_W-1:0]               pick_s;
    logic                           pick_found_s;
    int                             arb_idx_s;
    logic [STG_W-1:0]               stage_last_s;
    logic                           stage_is_last_s;
    logic                           active_next_s;

    // Round-robin pick: first snapshot request at or after last_sel+1, wrapping.
    // The snapshot taken in IDLE is never zero, so a winner always exists.
    always_comb begin
        pick_s       = last_sel_r;
        pick_found_s = 1'b0;
        arb_idx_s    = 0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            arb_idx_s = int'(last_sel_r) + i;
            if (arb_idx_s >= NUM_CORES) begin
                arb_idx_s = arb_idx_s - NUM_CORES;
            end else begin
                arb_idx_s = arb_idx_s;
            end
            if (!pick_found_s && req_snap_r[SEL_W'(arb_idx_s)]) begin
                pick_s       = SEL_W'(arb_idx_s);
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Stage bookkeeping: a load grant walks all read stages, an unload only one.
    always_comb begin
        if (load_r[sel_r]) begin
            stage_last_s = {STG_W{1'b0}};
        end else begin
            stage_last_s = STG_W'(NUM_READ_STAGES - 1);
        end
        stage_is_last_s = (stage_r == stage_last_s);
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|bus.w_req) begin
                    state_next_s = ST_ARB;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                state_next_s = ST_DESC;
            end
            ST_DESC: begin
                if (bus.w_desc_valid) begin
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_DESC;
                end
            end
            ST_HDR: begin
                if (!bus.w_mem_ready) begin
                    state_next_s = ST_HDR;
                end else if (burst_r != {BURST_WIDTH{1'b0}}) begin
                    state_next_s = ST_XFER;
                end else if (stage_is_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DESC;
                end
            end
            ST_XFER: begin
                if (!bus.w_mem_ready || (beat_r != (burst_r - BURST_WIDTH'(1)))) begin
                    state_next_s = ST_XFER;
                end else if (stage_is_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DESC;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: request snapshot, selection, descriptor latch,
    // beat/stage counters, per-core load/unload toggle.
    always_comb begin
        req_snap_next_s = req_snap_r;
        sel_next_s      = sel_r;
        last_sel_next_s = last_sel_r;
        load_next_s     = load_r;
        stage_next_s    = stage_r;
        beat_next_s     = beat_r;
        burst_next_s    = burst_r;
        base_next_s     = base_r;
        case (state_r)
            ST_IDLE: begin
                req_snap_next_s = bus.w_req;
                stage_next_s    = {STG_W{1'b0}};
                beat_next_s     = {BURST_WIDTH{1'b0}};
            end
            ST_ARB: begin
                sel_next_s = pick_s;
            end
            ST_DESC: begin
                if (bus.w_desc_valid) begin
                    base_next_s  = bus.w_desc_addr;
                    burst_next_s = bus.w_desc_burst;
                    beat_next_s  = {BURST_WIDTH{1'b0}};
                end else begin
                    beat_next_s  = beat_r;
                end
            end
            ST_HDR: begin
                beat_next_s = {BURST_WIDTH{1'b0}};
                if (state_next_s == ST_DESC) begin
                    stage_next_s = stage_r + STG_W'(1);
                end else begin
                    stage_next_s = stage_r;
                end
            end
            ST_XFER: begin
                if (bus.w_mem_ready) begin
                    beat_next_s = beat_r + BURST_WIDTH'(1);
                end else begin
                    beat_next_s = beat_r;
                end
                if (state_next_s == ST_DESC) begin
                    stage_next_s = stage_r + STG_W'(1);
                end else begin
                    stage_next_s = stage_r;
                end
            end
            ST_DONE: begin
                last_sel_next_s     = sel_r;
                load_next_s[sel_r]  = ~load_r[sel_r];
                stage_next_s        = {STG_W{1'b0}};
            end
            default: begin
                stage_next_s = {STG_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_r    <= ST_IDLE;
            req_snap_r <= {NUM_CORES{1'b0}};
            sel_r      <= {SEL_W{1'b0}};
            last_sel_r <= SEL_W'(NUM_CORES - 1);
            load_r     <= {NUM_CORES{1'b0}};
            stage_r    <= {STG_W{1'b0}};
            beat_r     <= {BURST_WIDTH{1'b0}};
            burst_r    <= {BURST_WIDTH{1'b0}};
            base_r     <= {MAIN_MEM_ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_next_s;
            req_snap_r <= req_snap_next_s;
            sel_r      <= sel_next_s;
            last_sel_r <= last_sel_next_s;
            load_r     <= load_next_s;
            stage_r    <= stage_next_s;
            beat_r     <= beat_next_s;
            burst_r    <= burst_next_s;
            base_r     <= base_next_s;
        end
    end

    // Output decode from the next state, so registered outputs match the state
    // entered on the same edge. Unused payloads are forced to zero.
    always_comb begin
        active_next_s      = (state_next_s == ST_DESC) || (state_next_s == ST_HDR) ||
                             (state_next_s == ST_XFER) || (state_next_s == ST_DONE);
        desc_ready_next_s  = (state_next_s == ST_DESC);
        burst_valid_next_s = (state_next_s == ST_HDR);
        addr_valid_next_s  = (state_next_s == ST_XFER);
        busy_next_s        = (state_next_s != ST_IDLE);
        if (active_next_s) begin
            grant_next_s = {{(NUM_CORES-1){1'b0}}, 1'b1} << sel_next_s;
            rw_next_s    = ~load_r[sel_next_s];
        end else begin
            grant_next_s = {NUM_CORES{1'b0}};
            rw_next_s    = 1'b0;
        end
        if (burst_valid_next_s) begin
            burst_out_next_s = burst_next_s;
        end else begin
            burst_out_next_s = {BURST_WIDTH{1'b0}};
        end
        if (addr_valid_next_s) begin
            addr_out_next_s = base_next_s + {{PAD_W{1'b0}}, beat_next_s};
        end else begin
            addr_out_next_s = {MAIN_MEM_ADDR_WIDTH{1'b0}};
        end
    end

    // Output registers
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            grant_r       <= {NUM_CORES{1'b0}};
            desc_ready_r  <= 1'b0;
            burst_valid_r <= 1'b0;
            burst_out_r   <= {BURST_WIDTH{1'b0}};
            addr_valid_r  <= 1'b0;
            addr_out_r    <= {MAIN_MEM_ADDR_WIDTH{1'b0}};
            rw_r          <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            grant_r       <= grant_next_s;
            desc_ready_r  <= desc_ready_next_s;
            burst_valid_r <= burst_valid_next_s;
            burst_out_r   <= burst_out_next_s;
            addr_valid_r  <= addr_valid_next_s;
            addr_out_r    <= addr_out_next_s;
            rw_r          <= rw_next_s;
            busy_r        <= busy_next_s;
        end
    end

    assign bus.w_grant       = grant_r;
    assign bus.w_desc_ready  = desc_ready_r;
    assign bus.w_burst_valid = burst_valid_r;
    assign bus.w_burst       = burst_out_r;
    assign bus.w_addr_valid  = addr_valid_r;
    assign bus.w_addr        = addr_out_r;
    assign bus.w_rw          = rw_r;
    assign bus.w_busy        = busy_r;

endmodule

// File: tb/tb_arbiter_rr_desc.sv
// ---------------------------------------------------------------------------
// tb_arbiter_rr_desc
// Scoreboard bench: each granted descriptor pushes its expected header and
// beats (with grant and direction) into a queue; a negedge monitor pops and
// compares them as the arbiter emits them, and checks stalled values against
// the queue head so any change while w_mem_ready is low is caught.
// ---------------------------------------------------------------------------
module tb_arbiter_rr_desc;

    localparam int AW  = 32;
    localparam int NC  = 4;
    localparam int BW  = 6;
    localparam int NRS = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] burst;
    } desc_t;

    typedef struct {
        bit            is_beat;
        logic [AW-1:0] val;
        logic [NC-1:0] grant;
        bit            rw;
    } exp_t;

    logic w_clock = 1'b0;
    logic w_reset_n;

    arbiter_rr_desc_if #(.MAIN_MEM_ADDR_WIDTH(AW), .NUM_CORES(NC), .BURST_WIDTH(BW)) bus ();

    arbiter_rr_desc #(
        .MAIN_MEM_ADDR_WIDTH(AW), .NUM_CORES(NC), .BURST_WIDTH(BW), .NUM_READ_STAGES(NRS)
    ) dut (
        .w_clock   (w_clock),
        .w_reset_n (w_reset_n),
        .bus       (bus)
    );

    always #5 w_clock = ~w_clock;

    int    check_cnt = 0;
    int    err_cnt   = 0;
    desc_t pool[$];
    desc_t desc_q[$];
    exp_t  sb_q[$];
    logic [NC-1:0] grant_log[$];
    logic [NC-1:0] prev_grant = '0;
    bit    mode_m[NC];
    int    last_m     = NC - 1;
    bit    bp_mode    = 1'b0;
    int    hold_cnt   = 0;
    int    ready_wait = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [NC-1:0] r);
        int idx;
        for (int i = 1; i <= NC; i++) begin
            idx = (last_m + i) % NC;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Model one grant: take descriptors from the pool, queue them for the
    // descriptor driver and push the expected header/beat stream.
    task automatic do_grant(input logic [NC-1:0] r);
        int    sel;
        int    n;
        desc_t d;
        exp_t  e;
        sel = pick(r);
        if (sel < 0) return;
        n = mode_m[sel] ? 1 : NRS;
        for (int s = 0; s < n; s++) begin
            if (pool.size() == 0) break;
            d = pool.pop_front();
            desc_q.push_back(d);
            e.is_beat = 1'b0;
            e.val     = AW'(d.burst);
            e.grant   = NC'(1) << sel;
            e.rw      = !mode_m[sel];
            sb_q.push_back(e);
            for (int b = 0; b < int'(d.burst); b++) begin
                e.is_beat = 1'b1;
                e.val     = d.addr + AW'(b);
                sb_q.push_back(e);
            end
        end
        mode_m[sel] = !mode_m[sel];
        last_m      = sel;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_grant"}, bus.w_grant, 0);
        check_eq({tag, "_busy"}, bus.w_busy, 0);
        check_eq({tag, "_ready"}, bus.w_desc_ready, 0);
        check_eq({tag, "_bvalid"}, bus.w_burst_valid, 0);
        check_eq({tag, "_avalid"}, bus.w_addr_valid, 0);
        check_eq({tag, "_burst"}, bus.w_burst, 0);
        check_eq({tag, "_addr"}, bus.w_addr, 0);
        check_eq({tag, "_rw"}, bus.w_rw, 0);
    endtask

    // Drive a request pattern; 'keep' holds it, otherwise it drops once granted.
    task automatic run_req(input logic [NC-1:0] r, input bit keep);
        int cyc;
        bus.w_req = r;
        if (!keep) begin
            cyc = 0;
            while (bus.w_grant == '0) begin
                @(posedge w_clock); #1;
                cyc++;
                if (cyc > 50) begin
                    check_eq("grant_timeout", bus.w_grant, r);
                    break;
                end
            end
            bus.w_req = '0;
        end
        cyc = 0;
        while (sb_q.size() != 0 || desc_q.size() != 0) begin
            @(posedge w_clock); #1;
            cyc++;
            if (cyc > 2000) begin
                check_eq("stream_timeout", sb_q.size(), 0);
                break;
            end
        end
        bus.w_req = '0;
        cyc = 0;
        while (bus.w_busy) begin
            @(posedge w_clock); #1;
            cyc++;
            if (cyc > 50) begin
                check_eq("idle_timeout", bus.w_busy, 0);
                break;
            end
        end
        check_eq("grant_clear", bus.w_grant, 0);
    endtask

    // Memory ready: constant, or toggling every cycle for backpressure.
    initial begin
        bus.w_mem_ready = 1'b1;
        forever begin
            @(posedge w_clock); #1;
            bus.w_mem_ready = bp_mode ? ~bus.w_mem_ready : 1'b1;
        end
    end

    // Descriptor driver: presents the queue head, optionally withholding valid
    // for hold_cnt cycles in which the arbiter is ready.
    initial begin
        bit fire;
        bus.w_desc_valid = 1'b0;
        bus.w_desc_addr  = '0;
        bus.w_desc_burst = '0;
        forever begin
            @(negedge w_clock);
            fire = bus.w_desc_valid && bus.w_desc_ready;
            if (bus.w_desc_ready && !bus.w_desc_valid && hold_cnt > 0) hold_cnt--;
            @(posedge w_clock); #1;
            if (fire && desc_q.size() > 0) void'(desc_q.pop_front());
            if (desc_q.size() > 0 && hold_cnt == 0) begin
                bus.w_desc_valid = 1'b1;
                bus.w_desc_addr  = desc_q[0].addr;
                bus.w_desc_burst = desc_q[0].burst;
            end else begin
                bus.w_desc_valid = 1'b0;
                bus.w_desc_addr  = '0;
                bus.w_desc_burst = '0;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge w_clock) begin
        exp_t e;
        check_eq("valid_excl", $onehot0({bus.w_desc_ready, bus.w_burst_valid, bus.w_addr_valid}), 1);
        if (!bus.w_burst_valid) check_eq("burst_zero", bus.w_burst, 0);
        if (!bus.w_addr_valid) check_eq("addr_zero", bus.w_addr, 0);
        if (bus.w_desc_ready && !bus.w_desc_valid) ready_wait++;
        if (bus.w_grant != '0 && prev_grant == '0) grant_log.push_back(bus.w_grant);
        prev_grant = bus.w_grant;
        if (bus.w_burst_valid || bus.w_addr_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_xfer", {bus.w_burst_valid, bus.w_addr_valid}, 0);
            end else begin
                e = sb_q[0];
                check_eq("kind", bus.w_addr_valid, e.is_beat);
                check_eq(e.is_beat ? "addr" : "hdr_burst",
                         e.is_beat ? 64'(bus.w_addr) : 64'(bus.w_burst), e.val);
                check_eq("grant", bus.w_grant, e.grant);
                check_eq("rw", bus.w_rw, e.rw);
                if (bus.w_mem_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [NC-1:0] exp_order [5];
        int cyc;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        for (int i = 0; i < NC; i++) mode_m[i] = 1'b0;
        bus.w_req = '0;
        w_reset_n = 1'b1;
        #1 w_reset_n = 1'b0;
        #11;
        check_idle_outputs("reset");
        @(negedge w_clock);
        w_reset_n = 1'b1;
        @(posedge w_clock); #1;

        // Single read grant to core 1
        pool.push_back('{32'h100, 6'd4});
        pool.push_back('{32'h200, 6'd2});
        pool.push_back('{32'h300, 6'd1});
        do_grant(4'b0010);
        run_req(4'b0010, 1'b0);

        // Second grant to core 1 is an unload
        pool.push_back('{32'h400, 6'd3});
        do_grant(4'b0010);
        run_req(4'b0010, 1'b0);

        // Third grant to core 1 loads again
        pool.push_back('{32'h120, 6'd1});
        pool.push_back('{32'h130, 6'd1});
        pool.push_back('{32'h140, 6'd2});
        do_grant(4'b0010);
        run_req(4'b0010, 1'b0);

        // Backpressure and address wrap on core 2
        bp_mode = 1'b1;
        pool.push_back('{32'hFFFF_FFFE, 6'd4});
        pool.push_back('{32'h50, 6'd2});
        pool.push_back('{32'h60, 6'd1});
        do_grant(4'b0100);
        run_req(4'b0100, 1'b0);
        bp_mode = 1'b0;
        repeat (2) @(posedge w_clock);
        #1;

        // Zero-length bursts and a late descriptor on core 3
        hold_cnt   = 5;
        ready_wait = 0;
        pool.push_back('{32'h500, 6'd0});
        pool.push_back('{32'h600, 6'd1});
        pool.push_back('{32'h700, 6'd0});
        do_grant(4'b1000);
        run_req(4'b1000, 1'b0);
        check_eq("desc_wait_cycles", ready_wait, 5);

        // Core 0 load, then reset in the middle of its unload
        pool.push_back('{32'h900, 6'd1});
        pool.push_back('{32'h910, 6'd1});
        pool.push_back('{32'h920, 6'd1});
        do_grant(4'b0001);
        run_req(4'b0001, 1'b0);
        pool.push_back('{32'h800, 6'd4});
        do_grant(4'b0001);
        bus.w_req = 4'b0001;
        cyc = 0;
        while (!(bus.w_addr_valid && bus.w_addr == 32'h802)) begin
            @(posedge w_clock); #1;
            cyc++;
            if (cyc > 100) begin
                check_eq("beat2_timeout", bus.w_addr, 32'h802);
                break;
            end
        end
        bus.w_req = '0;
        #2 w_reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        sb_q.delete();
        desc_q.delete();
        pool.delete();
        for (int i = 0; i < NC; i++) mode_m[i] = 1'b0;
        last_m = NC - 1;
        repeat (2) @(posedge w_clock);
        #3 w_reset_n = 1'b1;
        @(posedge w_clock); #1;

        // Round-robin with all requests held: core 0 first after reset, as a load
        grant_log.delete();
        for (int i = 0; i < 13; i++) pool.push_back('{AW'(32'h1000 + 32'h40 * i), BW'(1 + (i % 2))});
        for (int k = 0; k < 5; k++) do_grant(4'b1111);
        run_req(4'b1111, 1'b1);
        check_eq("rr_count", grant_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) check_eq("rr_order", grant_log[k], exp_order[k]);
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
